// File: rtl/xcore_fifo_syn_ext_pkg.sv
// rtl/xcore_fifo_syn_ext_pkg.sv - shared reset-value constants for the xcore FIFO.
// XCORE_FIFO_PARITY_EN is left undefined by default; define it at build time to enable entry parity.
package xcore_fifo_syn_ext_pkg;

  localparam logic RST_EMPTY  = 1'b1;
  localparam logic RST_FULL   = 1'b0;
  localparam logic RST_AEMPTY = 1'b1;
  localparam logic RST_AFULL  = 1'b0;
  localparam logic RST_VALID  = 1'b0;
  localparam logic RST_ERR    = 1'b0;

endpackage

// File: rtl/xcore_fifo_syn_ext_mem.sv
// rtl/xcore_fifo_syn_ext_mem.sv - 1W1R register array, synchronous write, asynchronous read.
module xcore_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/xcore_fifo_syn_ext.sv
// rtl/xcore_fifo_syn_ext.sv - parametrised single-clock FIFO, any depth, registered or FWFT read.
// Optional entry parity checking is enabled by defining XCORE_FIFO_PARITY_EN.
module xcore_fifo_syn_ext
  import xcore_fifo_syn_ext_pkg::*;
#(
  parameter int FIFO_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 64,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 4,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = 0,
  localparam int FIFO_PTR     = $clog2(FIFO_DEPTH)
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_flush,
  input  logic                  i_clr_err,
  input  logic [FIFO_WIDTH-1:0] i_data,
  input  logic                  i_write_en,
  input  logic                  i_read_en,
  output logic [FIFO_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_fifo_empty,
  output logic                  o_fifo_full,
  output logic                  o_almost_empty,
  output logic                  o_almost_full,
  output logic [FIFO_PTR:0]     o_data_avail,
  output logic [FIFO_PTR:0]     o_room_avail,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic                  o_parity_err
);

`ifdef XCORE_FIFO_PARITY_EN
  localparam int MEM_W = FIFO_WIDTH + 1;
`else
  localparam int MEM_W = FIFO_WIDTH;
`endif
  localparam int CW = FIFO_PTR + 1;
  localparam logic [FIFO_PTR-1:0] LAST_PTR = FIFO_PTR'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [FIFO_PTR-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, room_q;
  logic                  empty_q, full_q, aempty_q, afull_q;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic                  valid_q;
  logic                  wr_acc, rd_acc;
  logic [MEM_W-1:0]      mem_wdata, mem_rdata;

  function automatic logic [FIFO_PTR-1:0] ptr_inc(input logic [FIFO_PTR-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Flush masks both requests so a same-cycle write never lands in memory.
  assign wr_acc = i_write_en & ~full_q & ~i_flush;
  assign rd_acc = i_read_en & ~empty_q & ~i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    end
    ovf_d  = (i_write_en & full_q & ~i_flush) | (ovf_q & ~i_clr_err);
    unf_d  = (i_read_en & empty_q & ~i_flush) | (unf_q & ~i_clr_err);
    data_d = rd_acc ? mem_rdata[FIFO_WIDTH-1:0] : data_q;
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      room_q   <= DEPTH_C;
      empty_q  <= RST_EMPTY;
      full_q   <= RST_FULL;
      aempty_q <= RST_AEMPTY;
      afull_q  <= RST_AFULL;
      ovf_q    <= RST_ERR;
      unf_q    <= RST_ERR;
      data_q   <= '0;
      valid_q  <= RST_VALID;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      room_q   <= DEPTH_C - count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == DEPTH_C);
      aempty_q <= (count_d <= AEMPTY_C);
      afull_q  <= (count_d >= AFULL_C);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      data_q   <= data_d;
      valid_q  <= rd_acc;
    end
  end

`ifdef XCORE_FIFO_PARITY_EN
  logic parity_err_q;
  assign mem_wdata = {^i_data, i_data};
  // Even parity over data plus stored bit must reduce to zero on a clean entry.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) parity_err_q <= RST_ERR;
    else            parity_err_q <= (rd_acc & (^mem_rdata)) | (parity_err_q & ~i_clr_err);
  end
  assign o_parity_err = parity_err_q;
`else
  assign mem_wdata    = i_data;
  assign o_parity_err = 1'b0;
`endif

  xcore_fifo_mem #(.WIDTH(MEM_W), .DEPTH(FIFO_DEPTH), .AW(FIFO_PTR)) u_mem (
    .clk   (i_sys_clk),
    .wen   (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (mem_wdata),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign o_data       = mem_rdata[FIFO_WIDTH-1:0];
      assign o_data_valid = ~empty_q;
    end else begin : g_reg
      assign o_data       = data_q;
      assign o_data_valid = valid_q;
    end
  endgenerate

  assign o_fifo_empty   = empty_q;
  assign o_fifo_full    = full_q;
  assign o_almost_empty = aempty_q;
  assign o_almost_full  = afull_q;
  assign o_data_avail   = count_q;
  assign o_room_avail   = room_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

endmodule
